fetch_bp: RTL and testbench

FETCH_BP -- requirements
Module: fetch_bp

---
 rtl/fetch_bp.sv | 119 +++++++++++
 tb/tb_fetch_bp.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_bp.sv
// Instruction fetch stage: synchronous imem read, stall/hazard handling, and an
// optional bimodal predictor built when FETCH_BHT_EN is defined.
module fetch_bp #(
    parameter int BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    output logic [13:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        d_valid,
    output logic [13:0] d_pc,
    output logic [31:0] d_inst,
    output logic        d_pred,
    input  logic        b_is_hazard,
    input  logic [13:0] b_addr,
    input  logic        b_is_b_ope,
    input  logic        b_is_branch,
    input  logic [13:0] b_w_pc
);
    logic [13:0] pc_q;
    logic [13:0] f_pc_q;
    logic        f_valid_q;
    logic [13:0] pc_next;
    logic [13:0] f_pc_next;
    logic        f_valid_next;

    logic [5:0]  ope;
    logic        is_cond_br;
    logic [13:0] br_target;

    assign ope        = imem_data[31:26];
    assign is_cond_br = (ope[1:0] == 2'b10) && (ope[5:4] != 2'b00);
    assign br_target  = imem_data[13:0];

    // While stalled the held address is re-read so imem_data stays matched to d_pc.
    assign imem_addr = (stall && !b_is_hazard) ? f_pc_q : pc_q;
    assign d_pc      = f_pc_q;
    assign d_inst    = imem_data;
    assign d_valid   = f_valid_q & ~b_is_hazard;

`ifdef FETCH_BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [BHT_N-1:0]     bht_taken;
    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] wr_idx;

    assign rd_idx = f_pc_q[BHT_IDX_W-1:0];
    assign wr_idx = b_w_pc[BHT_IDX_W-1:0];

    // One saturating counter per entry; the read path sees the pre-update value.
    generate
        for (genvar gi = 0; gi < BHT_N; gi++) begin : g_bht
            logic [1:0] ctr_reg;
            logic [1:0] ctr_next;

            always_comb begin
                ctr_next = ctr_reg;
                if (b_is_b_ope && (wr_idx == BHT_IDX_W'(gi))) begin
                    if (b_is_branch) begin
                        if (ctr_reg != 2'b11) ctr_next = ctr_reg + 2'b01;
                    end else begin
                        if (ctr_reg != 2'b00) ctr_next = ctr_reg - 2'b01;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) ctr_reg <= 2'b01;
                else       ctr_reg <= ctr_next;
            end

            assign bht_taken[gi] = ctr_reg[1];
        end
    endgenerate

    assign d_pred = bht_taken[rd_idx] & is_cond_br & d_valid;
`else
    localparam int unused_idx_w = BHT_IDX_W;
    logic unused_bht;
    assign unused_bht = &{1'b0, b_is_b_ope, b_is_branch, b_w_pc, is_cond_br};
    assign d_pred     = 1'b0;
`endif

    always_comb begin
        pc_next      = pc_q;
        f_pc_next    = f_pc_q;
        f_valid_next = f_valid_q;
        if (b_is_hazard) begin
            pc_next      = b_addr;
            f_pc_next    = b_addr;
            f_valid_next = 1'b0;
        end else if (!stall) begin
            if (d_pred) begin
                // Redirect re-issues the target next cycle: one bubble.
                pc_next      = br_target;
                f_pc_next    = br_target;
                f_valid_next = 1'b0;
            end else begin
                f_pc_next    = pc_q;
                f_valid_next = 1'b1;
                pc_next      = pc_q + 14'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q      <= 14'd0;
            f_pc_q    <= 14'd0;
            f_valid_q <= 1'b0;
        end else begin
            pc_q      <= pc_next;
            f_pc_q    <= f_pc_next;
            f_valid_q <= f_valid_next;
        end
    end
endmodule

// File: tb/tb_fetch_bp.sv
// Testbench for fetch_bp: directed scenarios plus randomized traffic against a
// cycle-level reference model; build with FETCH_BHT_EN to match the DUT build.
module tb_fetch_bp;
`ifdef FETCH_BHT_EN
    localparam bit BHT_EN = 1'b1;
`else
    localparam bit BHT_EN = 1'b0;
`endif
    localparam int NPC  = 16384;
    localparam int NBHT = 64;

    logic        clk = 1'b0;
    logic        rstn, stall, b_is_hazard, b_is_b_ope, b_is_branch;
    logic [13:0] b_addr, b_w_pc, imem_addr, d_pc;
    logic [31:0] imem_data, d_inst;
    logic        d_valid, d_pred;

    logic [31:0] mem [NPC];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          m_pc, m_fpc;
    bit          m_fv;
    logic [31:0] m_data;
    int          bht [NBHT];
    int          exp_addr, exp_pc;
    bit          exp_valid, exp_pred;

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    fetch_bp #(.BHT_IDX_W(6)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .d_valid(d_valid), .d_pc(d_pc), .d_inst(d_inst), .d_pred(d_pred),
        .b_is_hazard(b_is_hazard), .b_addr(b_addr),
        .b_is_b_ope(b_is_b_ope), .b_is_branch(b_is_branch), .b_w_pc(b_w_pc)
    );

    function automatic bit is_cbr(input logic [31:0] w);
        return (w[27:26] == 2'b10) && (w[31:30] != 2'b00);
    endfunction

    // Apply inputs for this cycle and derive the expected combinational outputs.
    task automatic drive(input bit rs, input bit st, input bit hz, input int ba,
                         input bit bo, input bit bb, input int bw);
        rstn = rs; stall = st; b_is_hazard = hz; b_addr = 14'(ba);
        b_is_b_ope = bo; b_is_branch = bb; b_w_pc = 14'(bw);
        #1;
        exp_addr  = (st && !hz) ? m_fpc : m_pc;
        exp_valid = m_fv && !hz;
        exp_pc    = m_fpc;
        exp_pred  = BHT_EN && exp_valid && is_cbr(m_data) && (bht[m_fpc % NBHT] >= 2);
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one clock edge in both DUT and model.
    task automatic tick();
        int tgt;
        int idx;
        @(posedge clk);
        tgt    = int'(m_data[13:0]);
        m_data = mem[exp_addr];
        if (!rstn) begin
            m_pc = 0; m_fpc = 0; m_fv = 0;
            foreach (bht[i]) bht[i] = 1;
        end else begin
            if (b_is_hazard) begin
                m_pc = int'(b_addr); m_fpc = int'(b_addr); m_fv = 0;
            end else if (!stall) begin
                if (exp_pred) begin
                    m_pc = tgt; m_fpc = tgt; m_fv = 0;
                end else begin
                    m_fpc = m_pc; m_fv = 1; m_pc = (m_pc + 1) % NPC;
                end
            end
            if (BHT_EN && b_is_b_ope) begin
                idx = int'(b_w_pc) % NBHT;
                if (b_is_branch) bht[idx] = (bht[idx] < 3) ? bht[idx] + 1 : 3;
                else             bht[idx] = (bht[idx] > 0) ? bht[idx] - 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 1, 1, 'h123, 1, 1, 'h40); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        idle();
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d_valid got %b exp 0", d_valid); end
        n_tests++; if (imem_addr !== 14'h0) begin n_fail++; $display("FAIL reset_imem_addr got %h exp 0000", imem_addr); end
        n_tests++; if (d_pc !== 14'h0) begin n_fail++; $display("FAIL reset_d_pc got %h exp 0000", d_pc); end
        $display("[TB] reset: imem_addr=%h d_valid=%b d_pc=%h", imem_addr, d_valid, d_pc);
    endtask

    task automatic test_sequential();
        for (int k = 0; k < 8; k++) begin
            idle();
            n_tests++; if (imem_addr !== 14'(k)) begin n_fail++; $display("FAIL seq_imem_addr k=%0d got %h exp %h", k, imem_addr, 14'(k)); end
            n_tests++; if (d_valid !== (k >= 1)) begin n_fail++; $display("FAIL seq_d_valid k=%0d got %b exp %b", k, d_valid, (k >= 1)); end
            if (k >= 1) begin
                n_tests++; if (d_pc !== 14'(k - 1)) begin n_fail++; $display("FAIL seq_d_pc k=%0d got %h exp %h", k, d_pc, 14'(k - 1)); end
                n_tests++; if (d_inst !== mem[k - 1]) begin n_fail++; $display("FAIL seq_d_inst k=%0d got %h exp %h", k, d_inst, mem[k - 1]); end
            end
            $display("[TB] seq k=%0d imem_addr=%h d_valid=%b d_pc=%h", k, imem_addr, d_valid, d_pc);
            tick();
        end
    endtask

    task automatic test_stall();
        drive(1, 0, 1, 4, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            n_tests++; if (d_pc !== 14'h5) begin n_fail++; $display("FAIL stall_d_pc k=%0d got %h exp 0005", k, d_pc); end
            n_tests++; if (imem_addr !== 14'h5) begin n_fail++; $display("FAIL stall_imem_addr k=%0d got %h exp 0005", k, imem_addr); end
            n_tests++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL stall_d_valid k=%0d got %b exp 1", k, d_valid); end
            n_tests++; if (d_inst !== mem[5]) begin n_fail++; $display("FAIL stall_d_inst k=%0d got %h exp %h", k, d_inst, mem[5]); end
            $display("[TB] stall k=%0d imem_addr=%h d_pc=%h", k, imem_addr, d_pc);
            tick();
        end
        idle();
        n_tests++; if (d_pc !== 14'h5 || d_valid !== 1'b1) begin n_fail++; $display("FAIL release_d_pc got %h/%b exp 0005/1", d_pc, d_valid); end
        n_tests++; if (imem_addr !== 14'h6) begin n_fail++; $display("FAIL release_imem_addr got %h exp 0006", imem_addr); end
        tick();
        idle();
        n_tests++; if (d_pc !== 14'h6 || d_valid !== 1'b1) begin n_fail++; $display("FAIL release_next_d_pc got %h/%b exp 0006/1", d_pc, d_valid); end
        $display("[TB] stall release: d_pc=%h d_valid=%b", d_pc, d_valid);
        tick();
    endtask

    task automatic test_hazard();
        drive(1, 1, 1, 'h100, 0, 0, 0);
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_d_valid got %b exp 0", d_valid); end
        tick();
        idle();
        n_tests++; if (imem_addr !== 14'h100) begin n_fail++; $display("FAIL hazard_imem_addr got %h exp 0100", imem_addr); end
        n_tests++; if (d_valid !== 1'b0) begin n_fail++; $display("FAIL hazard_bubble got %b exp 0", d_valid); end
        tick();
        idle();
        n_tests++; if (d_pc !== 14'h100 || d_valid !== 1'b1) begin n_fail++; $display("FAIL hazard_d_pc got %h/%b exp 0100/1", d_pc, d_valid); end
        n_tests++; if (d_inst !== mem['h100]) begin n_fail++; $display("FAIL hazard_d_inst got %h exp %h", d_inst, mem['h100]); end
        $display("[TB] hazard: d_pc=%h d_valid=%b", d_pc, d_valid);
        tick();
    endtask

    task automatic test_predict();
        for (int k = 0; k < 3; k++) begin drive(1, 1, 0, 0, 1, 1, 'h40); tick(); end
        drive(1, 0, 1, 'h40, 0, 0, 0); tick();
        idle();
        n_tests++; if (imem_addr !== 14'h40) begin n_fail++; $display("FAIL pred_imem_addr got %h exp 0040", imem_addr); end
        tick();
        idle();
        n_tests++; if (d_pc !== 14'h40 || d_valid !== 1'b1) begin n_fail++; $display("FAIL pred_d_pc got %h/%b exp 0040/1", d_pc, d_valid); end
        n_tests++; if (d_pred !== BHT_EN) begin n_fail++; $display("FAIL pred_taken got %b exp %b", d_pred, BHT_EN); end
        $display("[TB] predict trained: d_pc=%h d_pred=%b", d_pc, d_pred);
        tick();
        idle();
        n_tests++; if (d_valid !== !BHT_EN) begin n_fail++; $display("FAIL pred_bubble got %b exp %b", d_valid, !BHT_EN); end
        n_tests++; if (imem_addr !== (BHT_EN ? 14'h200 : 14'h42)) begin n_fail++; $display("FAIL pred_redirect_addr got %h exp %h", imem_addr, (BHT_EN ? 14'h200 : 14'h42)); end
        tick();
        idle();
        n_tests++; if (d_pc !== (BHT_EN ? 14'h200 : 14'h42) || d_valid !== 1'b1) begin n_fail++; $display("FAIL pred_target_d_pc got %h/%b exp %h/1", d_pc, d_valid, (BHT_EN ? 14'h200 : 14'h42)); end
        tick();
        for (int k = 0; k < 3; k++) begin drive(1, 1, 0, 0, 1, 0, 'h40); tick(); end
        drive(1, 0, 1, 'h40, 0, 0, 0); tick();
        idle(); tick();
        idle();
        n_tests++; if (d_pc !== 14'h40 || d_pred !== 1'b0) begin n_fail++; $display("FAIL untrained_pred got %h/%b exp 0040/0", d_pc, d_pred); end
        $display("[TB] predict untrained: d_pc=%h d_pred=%b", d_pc, d_pred);
        tick();
        idle();
        n_tests++; if (d_pc !== 14'h41 || d_valid !== 1'b1) begin n_fail++; $display("FAIL untrained_seq got %h/%b exp 0041/1", d_pc, d_valid); end
        tick();
    endtask

    // A not-taken update to the entry being read must not affect this cycle's prediction.
    task automatic test_same_cycle_bht();
        for (int k = 0; k < 2; k++) begin drive(1, 1, 0, 0, 1, 1, 'h40); tick(); end
        drive(1, 0, 1, 'h40, 0, 0, 0); tick();
        idle(); tick();
        drive(1, 0, 0, 0, 1, 0, 'h40);
        n_tests++; if (d_pc !== 14'h40 || d_pred !== BHT_EN) begin n_fail++; $display("FAIL bypass_pred got %h/%b exp 0040/%b", d_pc, d_pred, BHT_EN); end
        $display("[TB] same-cycle bht: d_pc=%h d_pred=%b", d_pc, d_pred);
        tick();
        idle();
        n_tests++; if (imem_addr !== (BHT_EN ? 14'h200 : 14'h42)) begin n_fail++; $display("FAIL bypass_redirect got %h exp %h", imem_addr, (BHT_EN ? 14'h200 : 14'h42)); end
        tick();
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, 'h3FFE, 0, 0, 0); tick();
        idle(); tick();
        idle(); tick();
        idle();
        n_tests++; if (imem_addr !== 14'h0) begin n_fail++; $display("FAIL wrap_imem_addr got %h exp 0000", imem_addr); end
        n_tests++; if (d_pc !== 14'h3FFF) begin n_fail++; $display("FAIL wrap_d_pc got %h exp 3fff", d_pc); end
        $display("[TB] wrap: imem_addr=%h d_pc=%h", imem_addr, d_pc);
        tick();
        idle();
        n_tests++; if (d_pc !== 14'h0 || d_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_next got %h/%b exp 0000/1", d_pc, d_valid); end
        tick();
    endtask

    task automatic test_random();
        int errs_before;
        for (int c = 0; c < 600; c++) begin
            errs_before = n_fail;
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                  $urandom_range(0, 255), ($urandom_range(0, 2) == 0), $urandom_range(0, 1), $urandom_range(0, 255));
            n_tests++; if (imem_addr !== 14'(exp_addr)) begin n_fail++; $display("FAIL rnd_imem_addr c=%0d got %h exp %h", c, imem_addr, 14'(exp_addr)); end
            n_tests++; if (d_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_d_valid c=%0d got %b exp %b", c, d_valid, exp_valid); end
            n_tests++; if (d_pc !== 14'(exp_pc)) begin n_fail++; $display("FAIL rnd_d_pc c=%0d got %h exp %h", c, d_pc, 14'(exp_pc)); end
            n_tests++; if (d_pred !== exp_pred) begin n_fail++; $display("FAIL rnd_d_pred c=%0d got %b exp %b", c, d_pred, exp_pred); end
            n_tests++; if (d_inst !== m_data) begin n_fail++; $display("FAIL rnd_d_inst c=%0d got %h exp %h", c, d_inst, m_data); end
            if (exp_valid) begin
                n_tests++; if (d_inst !== mem[exp_pc]) begin n_fail++; $display("FAIL rnd_align c=%0d got %h exp %h", c, d_inst, mem[exp_pc]); end
            end
            $display("[TB] rnd c=%0d rstn=%b stall=%b hz=%b addr=%h v=%b pc=%h pred=%b %s", c, rstn, stall, b_is_hazard,
                     imem_addr, d_valid, d_pc, d_pred, (n_fail == errs_before) ? "ok" : "bad");
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < NPC; i++) mem[i] = $urandom;
        mem['h0]    = 32'h0;
        mem['h40]   = {6'b010010, 12'h000, 14'h0200};
        mem['h200]  = 32'h0;
        mem['h3FFE] = 32'h0;
        mem['h3FFF] = 32'h0;
        m_pc = 0; m_fpc = 0; m_fv = 0; m_data = 32'h0;
        foreach (bht[i]) bht[i] = 1;
        rstn = 1'b0; stall = 1'b0; b_is_hazard = 1'b0; b_addr = '0;
        b_is_b_ope = 1'b0; b_is_branch = 1'b0; b_w_pc = '0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_hazard();
        test_predict();
        test_same_cycle_bht();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
